// File: rtl/nco_freq_est_pkg.sv
// Shared state type and sizing helpers for the NCO frequency estimator
// and its reciprocal divider.
package nco_est_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, DIVIDE, OUT} est_state_t;

    localparam int DEF_APR      = 16;
    localparam int DEF_LOG2NPER = 2;
    localparam int NPER         = 1 << DEF_LOG2NPER;
    localparam int NUM_SHIFT    = DEF_APR + DEF_LOG2NPER;

    function automatic int nper_of(input int log2nper);
        return 1 << log2nper;
    endfunction

    function automatic int num_shift_of(input int apr, input int log2nper);
        return apr + log2nper;
    endfunction

    function automatic int quot_width(input int apr);
        return apr;
    endfunction

    function automatic int rem_width(input int cw);
        return cw + 1;
    endfunction

endpackage

// File: rtl/nco_freq_est_if.sv
// Sample-in / estimate-out bundle of the NCO frequency estimator.
interface nco_freq_est_if #(
    parameter int mpr = 10,
    parameter int apr = 16
);
    logic signed [mpr-1:0] fsin_i;
    logic                  in_valid;
    logic [apr-1:0]        phi_inc_o;
    logic                  est_valid;
    logic                  ovf;
    logic                  busy;

    modport master (
        output fsin_i, in_valid,
        input  phi_inc_o, est_valid, ovf, busy
    );

    modport slave (
        input  fsin_i, in_valid,
        output phi_inc_o, est_valid, ovf, busy
    );
endinterface

// File: rtl/nco_recip_div.sv
// Sequential restoring divider: 2^num_shift / divisor, one quotient bit per
// clken cycle, MSB first; done pulses when the last bit has been produced.
module nco_recip_div
    import nco_est_pkg::*;
#(
    parameter int apr      = DEF_APR,
    parameter int LOG2NPER = DEF_LOG2NPER,
    parameter int CW       = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clken,
    input  logic                       start,
    input  logic [CW-1:0]              divisor,
    output logic [quot_width(apr)-1:0] quotient,
    output logic                       done
);
    localparam int QW = quot_width(apr);
    localparam int RW = rem_width(CW);
    localparam int BW = (QW > 1) ? $clog2(QW) : 1;
    // Dividend is a single 1 followed by zeros: the bits above the QW
    // quotient positions fold into this starting remainder (always < divisor).
    localparam int            INIT_SHIFT = num_shift_of(apr, LOG2NPER) - QW;
    localparam logic [RW-1:0] REM_INIT   = RW'(1) << INIT_SHIFT;

    logic [RW-1:0] rem_q, rem_shift, rem_next;
    logic [CW-1:0] den_q;
    logic [QW-1:0] quot_q;
    logic [BW-1:0] bit_cnt;
    logic          run_q, fits;

    always_comb begin
        rem_shift = rem_q << 1;
        fits      = rem_shift >= {1'b0, den_q};
        rem_next  = fits ? rem_shift - {1'b0, den_q} : rem_shift;
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q   <= '0;
            den_q   <= '0;
            quot_q  <= '0;
            bit_cnt <= '0;
            run_q   <= 1'b0;
            done    <= 1'b0;
        end else if (clken) begin
            done <= 1'b0;
            if (start) begin
                rem_q   <= REM_INIT;
                den_q   <= divisor;
                quot_q  <= '0;
                bit_cnt <= '0;
                run_q   <= 1'b1;
            end else if (run_q) begin
                rem_q   <= rem_next;
                quot_q  <= {quot_q[QW-2:0], fits};
                bit_cnt <= bit_cnt + BW'(1);
                if (bit_cnt == BW'(QW - 1)) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign quotient = quot_q;

endmodule

// File: rtl/nco_freq_est.sv
// Frequency estimator: counts samples over NPER rising zero crossings and
// converts the count into the equivalent NCO phase-increment word.
module nco_freq_est
    import nco_est_pkg::*;
#(
    parameter int mpr      = 10,
    parameter int apr      = DEF_APR,
    parameter int LOG2NPER = DEF_LOG2NPER,
    parameter int CW       = 20,
    parameter int HYST     = 8
) (
    input logic           clk,
    input logic           reset,
    input logic           clken,
    nco_freq_est_if.slave bus
);
    localparam int                    NPER_L    = nper_of(LOG2NPER);
    localparam int                    PW        = LOG2NPER + 1;
    localparam logic [CW-1:0]         SCNT_LAST = CW'((1 << CW) - 2);
    localparam logic signed [mpr-1:0] ARM_LEVEL = mpr'(-HYST);

    est_state_t     state_q, state_d;
    logic           armed_q;
    logic [CW-1:0]  scnt_q;
    logic [PW-1:0]  pcnt_q;
    logic [apr-1:0] phi_q;
    logic           ovf_q;
    logic [apr-1:0] quotient;
    logic           div_done;
    logic           accept, detect, arm_hit, crossing, last_cross, timeout;

    assign accept     = clken & bus.in_valid;
    assign detect     = accept & ((state_q == IDLE) | (state_q == COUNT));
    assign arm_hit    = bus.fsin_i <= ARM_LEVEL;
    assign crossing   = detect & armed_q & ~bus.fsin_i[mpr-1];
    assign last_cross = (state_q == COUNT) & crossing & (pcnt_q == PW'(NPER_L - 1));
    // Timeout fires on the sample that would bring scnt to all-ones.
    assign timeout    = (state_q == COUNT) & accept & ~last_cross & (scnt_q == SCNT_LAST);

    always_comb begin
        // NOTE: default first so no branch leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (crossing) state_d = COUNT;
            COUNT: begin
                if (last_cross)   state_d = DIVIDE;
                else if (timeout) state_d = OUT;
            end
            DIVIDE:  if (div_done) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)      state_q <= IDLE;
        else if (clken) state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q <= 1'b0;
            scnt_q  <= '0;
            pcnt_q  <= '0;
            phi_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clken) begin
            if (last_cross) begin
                armed_q <= 1'b0;
            end else if (detect) begin
                if (arm_hit)       armed_q <= 1'b1;
                else if (crossing) armed_q <= 1'b0;
            end

            if ((state_q == IDLE) && crossing) begin
                scnt_q <= '0;
                pcnt_q <= '0;
            end else if ((state_q == COUNT) && accept) begin
                scnt_q <= scnt_q + CW'(1);
                if (crossing) pcnt_q <= pcnt_q + PW'(1);
            end

            if ((state_q == DIVIDE) && div_done) begin
                phi_q <= quotient;
                ovf_q <= 1'b0;
            end else if (timeout) begin
                phi_q <= '0;
                ovf_q <= 1'b1;
            end
        end
    end

    nco_recip_div #(
        .apr      (apr),
        .LOG2NPER (LOG2NPER),
        .CW       (CW)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .clken    (clken),
        .start    (last_cross),
        .divisor  (scnt_q + CW'(1)),
        .quotient (quotient),
        .done     (div_done)
    );

    assign bus.phi_inc_o = phi_q;
    assign bus.est_valid = (state_q == OUT);
    assign bus.ovf       = ovf_q & (state_q == OUT);
    assign bus.busy      = (state_q == COUNT) | (state_q == DIVIDE);

endmodule

// File: tb/tb_nco_freq_est.sv
// Self-checking bench for nco_freq_est: table-driven tone vectors, corner
// sequences, and randomized tones against a crossing-index reference model.
module tb_nco_freq_est;
    localparam int  MPR    = 10;
    localparam int  APR    = 16;
    localparam int  L2     = 2;
    localparam int  NPERT  = 1 << L2;
    localparam int  CWT    = 12;
    localparam int  HYSTT  = 8;
    localparam int  MAXC   = (1 << CWT) - 1;
    localparam int  BUDGET = 30000;
    localparam real PI     = 3.14159265358979;

    typedef enum int {K_SINE, K_SQUARE, K_ALT, K_NOISY} kind_t;
    typedef struct {
        kind_t kind;
        int    period;
        int    amp;
        bit    stall;
        bit    chk_lat;
        int    exp_phi;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic clken;
    int   n_checks = 0;
    int   n_err    = 0;
    int   stim[$];

    nco_freq_est_if #(.mpr(MPR), .apr(APR)) bus ();

    nco_freq_est #(
        .mpr(MPR), .apr(APR), .LOG2NPER(L2), .CW(CWT), .HYST(HYSTT)
    ) dut (
        .clk(clk), .reset(reset), .clken(clken), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic ce, input logic vld, input int s);
        clken        = ce;
        bus.in_valid = vld;
        bus.fsin_i   = MPR'(s);
        @(posedge clk);
        #1;
    endtask

    task automatic gen_stim(input kind_t kind, input real per, input int amp, input int n);
        real off;
        off = real'($urandom_range(0, 999)) / 1000.0 * per;
        stim.delete();
        for (int i = 0; i < n; i++) begin
            int  s;
            real x;
            int  nz;
            case (kind)
                K_SQUARE: s = (((i + $rtoi(off)) % 64) < 32) ? amp : -amp;
                K_ALT:    s = (i % 2 == 0) ? -amp : amp;
                default: begin
                    x = real'(amp) * $sin(2.0 * PI * (real'(i) + off) / per);
                    s = $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
                    // Sign-preserving jitter near zero only moves arming, never crossings.
                    if (kind == K_NOISY && ((s >= 4 && s <= 16) || (s <= -4 && s >= -16))) begin
                        nz = int'($urandom_range(0, 6)) - 3;
                        s  = s + nz;
                    end
                end
            endcase
            stim.push_back(s);
        end
    endtask

    // Reference: locate rising crossings in the accepted-sample stream, then
    // S = samples from the first to the NPER-th following crossing.
    function automatic void model(output bit has, output bit m_ovf, output int m_phi,
                                  output int term);
        int cr[$];
        bit armed = 1'b0;
        has = 1'b0; m_ovf = 1'b0; m_phi = 0; term = -1;
        foreach (stim[i]) begin
            if (stim[i] <= -HYSTT) armed = 1'b1;
            else if (armed && stim[i] >= 0) begin
                cr.push_back(i);
                armed = 1'b0;
            end
        end
        if (cr.size() == 0) return;
        if (cr.size() > NPERT && cr[NPERT] - cr[0] <= MAXC) begin
            has   = 1'b1;
            term  = cr[NPERT];
            m_phi = (1 << (APR + L2)) / (cr[NPERT] - cr[0]);
        end else if (stim.size() - 1 - cr[0] >= MAXC) begin
            has   = 1'b1;
            m_ovf = 1'b1;
            term  = cr[0] + MAXC;
        end
    endfunction

    // Streams stim until est_valid; lat counts clken edges after the edge
    // that accepted sample term_idx. abort_at >= 0 pulses reset at that lat.
    task automatic run_meas(input bit stall, input int term_idx, input int abort_at,
                            output bit seen, output int lat);
        int             idx = 0;
        int             cyc = 0;
        int             burst = 0;
        int             frz = 0;
        bit             counting = 1'b0;
        logic           ce, v;
        logic [APR-1:0] p0;
        logic           e0, o0, b0;
        seen = 1'b0;
        lat  = -1;
        while (!seen && cyc < BUDGET) begin
            ce = 1'b1;
            v  = (idx < stim.size());
            if (stall) begin
                if (cyc % 3 == 2) v = 1'b0;
                if (burst > 0) begin
                    ce = 1'b0;
                    burst--;
                end else if ($urandom_range(0, 7) == 0) begin
                    ce    = 1'b0;
                    burst = int'($urandom_range(0, 3));
                end
            end
            p0 = bus.phi_inc_o; e0 = bus.est_valid; o0 = bus.ovf; b0 = bus.busy;
            tick(ce, v, (idx < stim.size()) ? stim[idx] : 0);
            if (!ce && (bus.phi_inc_o !== p0 || bus.est_valid !== e0 ||
                        bus.ovf !== o0 || bus.busy !== b0)) frz++;
            if (ce) begin
                if (counting) lat++;
                if (v && idx == term_idx) begin
                    counting = 1'b1;
                    lat      = 0;
                end
                if (v) idx++;
            end
            if (abort_at >= 0 && counting && lat == abort_at) begin
                reset = 1'b1;
                tick(1'b0, 1'b0, 0);
                reset = 1'b0;
                return;
            end
            if (bus.est_valid) seen = 1'b1;
            cyc++;
        end
        if (stall) check("clken_freeze", frz, 0);
    endtask

    task automatic meas(input string name, input bit stall, input bit chk_lat,
                        input bit use_exp, input int exp_phi, input bit exp_ovf);
        bit has, m_ovf, seen;
        int m_phi, term, lat;
        model(has, m_ovf, m_phi, term);
        if (!has) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_model: stimulus yields no measurement", name);
            return;
        end
        run_meas(stall, term, -1, seen, lat);
        check({name, "_est_seen"}, seen, 1);
        if (seen) begin
            check({name, "_phi_model"}, bus.phi_inc_o, m_phi);
            check({name, "_ovf_model"}, bus.ovf, m_ovf);
            if (use_exp) begin
                check({name, "_phi"}, bus.phi_inc_o, exp_phi);
                check({name, "_ovf"}, bus.ovf, exp_ovf);
            end
            if (chk_lat) check({name, "_latency"}, lat, APR + 1);
        end
        tick(1'b1, 1'b0, 0);
        check({name, "_est_pulse"}, bus.est_valid, 0);
        check({name, "_idle_busy"}, bus.busy, 0);
    endtask

    initial begin
        vec_t vecs[5];
        bit   has, m_ovf, seen;
        int   m_phi, term, lat, quiet;

        vecs[0] = '{K_SINE,   64, 500, 1'b0, 1'b1, 1024};
        vecs[1] = '{K_SQUARE, 64, 100, 1'b0, 1'b1, 1024};
        vecs[2] = '{K_ALT,     2, 100, 1'b0, 1'b1, 32768};
        vecs[3] = '{K_NOISY,  64,  60, 1'b0, 1'b0, 1024};
        vecs[4] = '{K_SINE,   64, 500, 1'b1, 1'b1, 1024};

        reset = 1'b1;
        tick(1'b1, 1'b0, 0);
        tick(1'b0, 1'b1, -100);
        reset = 1'b0;
        check("reset_phi", bus.phi_inc_o, 0);
        check("reset_est_valid", bus.est_valid, 0);
        check("reset_ovf", bus.ovf, 0);
        check("reset_busy", bus.busy, 0);

        foreach (vecs[i]) begin
            gen_stim(vecs[i].kind, real'(vecs[i].period), vecs[i].amp, vecs[i].period * 7 + 40);
            meas($sformatf("vec%0d", i), vecs[i].stall, vecs[i].chk_lat, 1'b1,
                 vecs[i].exp_phi, 1'b0);
        end

        // Signal inside the hysteresis band must never arm the detector.
        quiet = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 1'b1, int'($urandom_range(0, 14)) - 7);
            if (bus.busy || bus.est_valid) quiet++;
        end
        check("small_signal_idle", quiet, 0);

        // Reset a few cycles into the divide phase.
        gen_stim(K_SINE, 64.0, 500, 64 * 7 + 40);
        model(has, m_ovf, m_phi, term);
        run_meas(1'b0, term, 5, seen, lat);
        check("rst_mid_phi", bus.phi_inc_o, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_est", bus.est_valid, 0);
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b0, 0);
            if (bus.est_valid || bus.busy || bus.phi_inc_o != 0) quiet++;
        end
        check("rst_mid_quiet", quiet, 0);

        gen_stim(K_SINE, 50.0, 500, 50 * 7 + 40);
        meas("p50", 1'b0, 1'b1, 1'b1, 1310, 1'b0);

        // One crossing, then a constant positive level until the counter expires.
        stim.delete();
        stim.push_back(-50);
        for (int i = 0; i < MAXC + 100; i++) stim.push_back(50);
        meas("timeout", 1'b0, 1'b0, 1'b1, 0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            real per;
            per = 8.0 + real'($urandom_range(0, 1900)) / 10.0;
            gen_stim(K_SINE, per, 20 + int'($urandom_range(0, 480)), $rtoi(per * 7.0) + 40);
            meas($sformatf("rand%0d", r), bit'($urandom_range(0, 1)), 1'b1, 1'b0, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/nco_freq_est.md
Name: nco_freq_est

Overview:
- Measures the frequency of a sinusoid coming from the NCO sample stream (fsin_o/out_valid style).
- Returns the equivalent phase-increment word, so it is the receive-side inverse of the NCO's phi_inc -> sine path.
- Used in loopback self-test of the mixer chain, and to track an external tone.
- Method: count samples over NPER rising zero crossings, then run a sequential reciprocal divide.

Parameters:
- mpr, 10, input sample width (signed two's complement).
- apr, 16, phase-accumulator width; width of phi_inc_o.
- LOG2NPER, 2, log2 of the number of periods averaged; NPER = 2^LOG2NPER.
- CW, 20, sample-counter width; sets the timeout at 2^CW-1 samples.
- HYST, 8, arming threshold magnitude for the crossing detector (LSBs).

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- clken, in, 1, global clock enable; when low, all state freezes.
- fsin_i, in, mpr, signed sine sample.
- in_valid, in, 1, fsin_i is valid this cycle (qualified by clken).
- phi_inc_o, out, apr, estimated phase increment; held until the next estimate.
- est_valid, out, 1, one-clken-cycle pulse: phi_inc_o is updated.
- ovf, out, 1, qualifies est_valid: the measurement timed out and phi_inc_o=0.
- busy, out, 1, high in the COUNT and DIVIDE states.

Behaviour:
- Reset:
  - Synchronous, active-high; wins over clken.
  - Outputs: phi_inc_o=0, est_valid=0, ovf=0, busy=0.
  - Internal: state=IDLE, armed=0, counters=0.
- Sample acceptance: a sample is accepted only when clken=1 and in_valid=1. Nothing advances when clken=0.
- Crossing detector (every accepted sample, in IDLE and COUNT only):
  - If fsin_i <= -HYST, set armed=1.
  - If armed=1 and fsin_i >= 0, this sample is a rising crossing; clear armed.
  - A sample that both arms and crosses is impossible, because HYST>0.
- FSM states: IDLE, COUNT, DIVIDE, OUT.
  - IDLE: wait for a crossing. On a crossing go to COUNT with scnt=0 and pcnt=0.
  - COUNT:
    - Each accepted sample does scnt++, including the crossing sample. A crossing also does pcnt++.
    - When the crossing that makes pcnt=NPER is accepted, latch S=scnt+1 and go to DIVIDE.
    - If scnt reaches 2^CW-1 without that crossing (timeout), go to OUT with the timeout flag set.
  - DIVIDE:
    - Restoring division of 2^(apr+LOG2NPER) by S, one quotient bit per clken cycle, MSB first, apr cycles.
    - Input samples are ignored and the detector is not updated (armed is cleared on entry).
  - OUT: for one clken cycle, update registers, then go to IDLE.
    - Normal: phi_inc_o = quotient, est_valid=1, ovf=0.
    - Timeout: phi_inc_o = 0, est_valid=1, ovf=1.
- Arithmetic and ranges:
  - For an integer period P samples, S = NPER*P and the result is floor(2^apr / P).
  - Every crossing needs at least 2 samples, so S >= 2*NPER and the quotient is <= 2^(apr-1). No saturation logic is needed.
  - S is CW bits wide and the divider remainder is CW+1 bits. The quotient is truncated, not rounded.
- Latency: est_valid is high in the (apr+1)th clken cycle after the cycle that accepted the terminating crossing.
- Back-to-back operation: the next measurement starts at the first crossing after returning to IDLE. Between estimates, phi_inc_o holds its value.
- Reset mid-operation (COUNT or DIVIDE): return to IDLE, no est_valid, and phi_inc_o=0.

Decomposition:
- Shared package nco_est_pkg:
  - state enum {IDLE, COUNT, DIVIDE, OUT}.
  - localparams NPER and NUM_SHIFT = apr+LOG2NPER.
  - quotient width and remainder width functions of apr and CW.
- One sub-module, nco_recip_div: sequential restoring divider.
  - Inputs: start, divisor S, clken.
  - Outputs: quotient, done.
  - Contains the bit counter and the remainder register.
- The top level holds the detector, the counters and the FSM.

Test Plan:
- Ideal NCO samples, apr=16, phi_inc=1024 (P=64), amplitude ±500, in_valid=1 -> S=256, phi_inc_o=1024, ovf=0, est_valid exactly 17 clken cycles after the 4th counted crossing.
- Square wave +100×32 / -100×32 -> phi_inc_o=1024. Then alternate -100/+100 every sample (P=2) -> phi_inc_o=32768.
- Hysteresis: a P=64 sine with ±3 LSB noise superimposed at each zero region, HYST=8 -> phi_inc_o=1024, no extra crossings counted. A signal limited to ±7 -> never leaves IDLE, busy=0.
- Timeout: one crossing, then constant +50 -> after 2^20-1 counted samples, est_valid=1 with ovf=1 and phi_inc_o=0, then back to IDLE.
- Stalls: P=64 stream with in_valid=0 every third cycle and random clken=0 bursts -> phi_inc_o=1024. During clken=0 no state, counter or output changes.
- Reset: assert reset for 1 cycle mid-DIVIDE -> no est_valid pulse, phi_inc_o=0, state IDLE. Next full P=50 measurement -> phi_inc_o=1310.
